// File: rtl/cnn_load_pkg.sv
// Shared types and segment-length tables for the CNN parameter/image load sequencer.
package cnn_load_pkg;

  localparam int NL_DEF      = 6;
  localparam int IMG_CNT_DEF = 2304;
  localparam int CNT_W       = 13;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    LOAD_B   = 3'd2,
    LOAD_IMG = 3'd3,
    FIN      = 3'd4
  } ld_state_e;

  // Words per layer, in load order conv1..conv4, fc6, fc7.
  localparam logic [CNT_W-1:0] WCNT [NL_DEF] = '{13'd180, 13'd3600, 13'd4320, 13'd6048, 13'd6048, 13'd144};
  localparam logic [CNT_W-1:0] BCNT [NL_DEF] = '{13'd20, 13'd20, 13'd24, 13'd28, 13'd24, 13'd6};

endpackage

// File: rtl/layer_load_sched_seg_counter.sv
// Loadable terminal-count counter; flags the beat that completes the current segment
// and self-clears on it so the next segment starts from zero.
module seg_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         last_beat_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign last_beat_o = en_i && (cnt_q == limit_i - W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)            cnt_d = '0;
    else if (last_beat_o) cnt_d = '0;
    else if (en_i)        cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/layer_load_sched.sv
// Streams one host word sequence into every layer's weight/bias loader, then the image loader.
// Optional LDSCHED_SKIP_RELOAD_EN: start with params_valid_keep skips straight to the image once loaded.
module layer_load_sched
  import cnn_load_pkg::*;
#(
  parameter int BIT     = 32,
  parameter int NL      = NL_DEF,
  parameter int IMG_CNT = IMG_CNT_DEF
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           start,
  input  logic           abort,
`ifdef LDSCHED_SKIP_RELOAD_EN
  input  logic           params_valid_keep,
`endif
  input  logic [BIT-1:0] s_data,
  input  logic           s_valid,
  output logic           s_ready,
  output logic [BIT-1:0] data_out,
  output logic [NL-1:0]  control_weight,
  output logic [NL-1:0]  control_bias,
  output logic           control_image,
  output logic [2:0]     layer_idx,
  output logic           busy,
  output logic           done
);

  localparam logic [2:0] LAST_LAYER = 3'(NL - 1);
  localparam logic [2:0] IMG_LAYER  = 3'(NL);

  ld_state_e        state_q, state_d;
  logic [2:0]       layer_q, layer_d;
  logic [BIT-1:0]   data_q, data_d;
  logic [NL-1:0]    cw_q, cw_d, cb_q, cb_d;
  logic             ci_q, ci_d;
  logic             done_q, done_d;
  logic             beat, last_beat, cnt_clr, eff_abort, keep_ok;
  logic [CNT_W-1:0] seg_limit;

  assign s_ready   = (state_q == LOAD_W) || (state_q == LOAD_B) || (state_q == LOAD_IMG);
  assign busy      = (state_q != IDLE);
  assign beat      = s_valid && s_ready;
  assign eff_abort = abort && busy;
  assign cnt_clr   = eff_abort || ((state_q == IDLE) && start);

`ifdef LDSCHED_SKIP_RELOAD_EN
  logic loaded_q, loaded_d;

  assign keep_ok = params_valid_keep && loaded_q;

  always_comb begin
    loaded_d = loaded_q;
    if ((state_q == FIN) && !abort) loaded_d = 1'b1;
    if (eff_abort)                  loaded_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) loaded_q <= 1'b0;
    else      loaded_q <= loaded_d;
  end
`else
  assign keep_ok = 1'b0;
`endif

  always_comb begin
    case (state_q)
      LOAD_W:  seg_limit = WCNT[layer_q];
      LOAD_B:  seg_limit = BCNT[layer_q];
      default: seg_limit = CNT_W'(IMG_CNT);
    endcase
  end

  seg_counter #(.W(CNT_W)) u_seg_counter (
    .clk         (clk),
    .rst_        (rst_),
    .clr_i       (cnt_clr),
    .en_i        (beat),
    .limit_i     (seg_limit),
    .last_beat_o (last_beat)
  );

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = keep_ok ? LOAD_IMG : LOAD_W;
          layer_d = keep_ok ? IMG_LAYER : 3'd0;
        end
      end
      LOAD_W: begin
        if (last_beat) state_d = LOAD_B;
      end
      LOAD_B: begin
        if (last_beat) begin
          if (layer_q == LAST_LAYER) begin
            state_d = LOAD_IMG;
            layer_d = IMG_LAYER;
          end else begin
            state_d = LOAD_W;
            layer_d = layer_q + 3'd1;
          end
        end
      end
      LOAD_IMG: begin
        if (last_beat) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        layer_d = 3'd0;
      end
      default: begin
        state_d = IDLE;
        layer_d = 3'd0;
      end
    endcase
    // Abort wins over any segment transition, including the final one.
    if (eff_abort) begin
      state_d = IDLE;
      layer_d = 3'd0;
    end
  end

  // Strobes and data register one cycle behind the accepted beat.
  always_comb begin
    cw_d   = '0;
    cb_d   = '0;
    ci_d   = 1'b0;
    data_d = beat ? s_data : data_q;
    if (beat) begin
      case (state_q)
        LOAD_W:   cw_d = NL'(1) << layer_q;
        LOAD_B:   cb_d = NL'(1) << layer_q;
        LOAD_IMG: ci_d = 1'b1;
        default:  ci_d = 1'b0;
      endcase
    end
    // Registered so done follows the final image strobe by one cycle.
    done_d = (state_q == FIN) && !abort;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q <= IDLE;
      layer_q <= 3'd0;
      data_q  <= '0;
      cw_q    <= '0;
      cb_q    <= '0;
      ci_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      data_q  <= data_d;
      cw_q    <= cw_d;
      cb_q    <= cb_d;
      ci_q    <= ci_d;
      done_q  <= done_d;
    end
  end

  assign data_out       = data_q;
  assign control_weight = cw_q;
  assign control_bias   = cb_q;
  assign control_image  = ci_q;
  assign layer_idx      = layer_q;
  assign done           = done_q;

endmodule
